// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle synchronous instruction
// memory and presents {pc, instr, valid} to the IF/ID register.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4,
    parameter int unsigned IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               PCWrite,
    input  logic               Branch,
    input  logic [31:0]        BranchTarget,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        pc_out,
    output logic [31:0]        instr_out,
    output logic               valid_out
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        STALL,
        REDIRECT
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc, fetch_pc_nxt;
    logic [31:0] issue_pc, issue_pc_nxt;
    logic [31:0] hold_instr, hold_instr_nxt;
    logic        use_hold, use_hold_nxt;
    logic        valid_nxt;
    logic [31:0] target_aligned;
    logic        unused_target_bits;

    assign target_aligned     = {BranchTarget[31:2], 2'b00};
    assign unused_target_bits = ^BranchTarget[1:0];

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= BOOT;
            fetch_pc   <= RESET_PC;
            issue_pc   <= 32'h0;
            hold_instr <= 32'h0;
            use_hold   <= 1'b0;
            valid_out  <= 1'b0;
        end else begin
            state      <= state_nxt;
            fetch_pc   <= fetch_pc_nxt;
            issue_pc   <= issue_pc_nxt;
            hold_instr <= hold_instr_nxt;
            use_hold   <= use_hold_nxt;
            valid_out  <= valid_nxt;
        end
    end

    // Next-state, datapath update and memory enable
    always_comb begin
        state_nxt      = state;
        fetch_pc_nxt   = fetch_pc;
        issue_pc_nxt   = issue_pc;
        hold_instr_nxt = hold_instr;
        use_hold_nxt   = use_hold;
        valid_nxt      = valid_out;
        imem_en        = 1'b0;

        case (state)
            BOOT: begin
                imem_en      = 1'b1;
                issue_pc_nxt = fetch_pc;
                fetch_pc_nxt = fetch_pc + STEP;
                valid_nxt    = 1'b1;
                state_nxt    = RUN;
            end
            RUN, STALL: begin
                if (PCWrite) begin
                    // Resuming from STALL must issue the read it skipped
                    imem_en      = 1'b1;
                    use_hold_nxt = 1'b0;
                    if (Branch) begin
                        fetch_pc_nxt = target_aligned;
                        valid_nxt    = 1'b0;
                        state_nxt    = REDIRECT;
                    end else begin
                        issue_pc_nxt = fetch_pc;
                        fetch_pc_nxt = fetch_pc + STEP;
                        valid_nxt    = 1'b1;
                        state_nxt    = RUN;
                    end
                end else begin
                    if (!use_hold) begin
                        hold_instr_nxt = imem_rdata;
                        use_hold_nxt   = 1'b1;
                    end
                    state_nxt = STALL;
                end
            end
            REDIRECT: begin
                imem_en = 1'b1;
                if (PCWrite) begin
                    issue_pc_nxt = fetch_pc;
                    fetch_pc_nxt = fetch_pc + STEP;
                    valid_nxt    = 1'b1;
                    state_nxt    = RUN;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    assign imem_addr = fetch_pc[IMEM_AW+1:2];
    assign pc_out    = issue_pc;
    assign instr_out = !valid_out ? 32'h0 : (use_hold ? hold_instr : imem_rdata);

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed test-plan steps followed by random
// stall/branch/reset traffic, checked against a presentation-level model.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCWrite;
    logic        Branch;
    logic [31:0] BranchTarget;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        valid_out;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: what is presented, and the next address to be presented
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_next;
    logic        m_boot;
    logic        m_redir;

    if_fetch #(.RESET_PC(32'h0), .PC_STEP(4), .IMEM_AW(10)) dut (
        .clk(clk), .reset(reset), .PCWrite(PCWrite), .Branch(Branch),
        .BranchTarget(BranchTarget), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .pc_out(pc_out), .instr_out(instr_out),
        .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] byte_addr);
        return 32'hA000_0000 + {22'h0, byte_addr[11:2]};
    endfunction

    // Synchronous memory; output is garbage on cycles with no read issued
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem_word({20'h0, imem_addr, 2'b00});
        else         imem_rdata <= $urandom();
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic present_next();
        m_valid = 1'b1;
        m_pc    = m_next;
        m_next  = m_next + 32'd4;
    endtask

    task automatic step(input logic rst, input logic pw, input logic br, input logic [31:0] tgt);
        logic exp_en;
        reset = rst; PCWrite = pw; Branch = br; BranchTarget = tgt;
        #1;
        if (!rst) begin
            exp_en = m_boot || m_redir || pw;
            chk("imem_en", 32'(imem_en), 32'(exp_en));
            if (exp_en) chk("imem_addr", 32'(imem_addr), 32'(m_next[11:2]));
        end
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_pc = 32'h0; m_next = 32'h0; m_boot = 1'b1; m_redir = 1'b0;
        end else if (m_boot) begin
            present_next();
            m_boot = 1'b0;
        end else if (m_redir) begin
            if (pw) begin
                present_next();
                m_redir = 1'b0;
            end
        end else if (pw && br) begin
            m_valid = 1'b0;
            m_next  = tgt & 32'hFFFF_FFFC;
            m_redir = 1'b1;
        end else if (pw) begin
            present_next();
        end
        #1;
        chk("valid_out", 32'(valid_out), 32'(m_valid));
        chk("pc_out", pc_out, m_pc);
        chk("instr_out", instr_out, m_valid ? mem_word(m_pc) : 32'h0);
    endtask

    initial begin
        m_valid = 1'b0; m_pc = 32'h0; m_next = 32'h0; m_boot = 1'b1; m_redir = 1'b0;

        // Reset, then free run
        step(1, 0, 0, 0);
        step(1, 1, 1, 32'h100);
        chk("rst_valid", 32'(valid_out), 32'h0);
        chk("rst_instr", instr_out, 32'h0);
        step(0, 1, 0, 0);
        chk("first_pc", pc_out, 32'h0);
        chk("first_instr", instr_out, 32'hA000_0000);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("run_pc8", pc_out, 32'h8);

        // Three-cycle stall at pc 8
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            chk("stall_pc", pc_out, 32'h8);
            chk("stall_instr", instr_out, 32'hA000_0002);
            chk("stall_en", 32'(imem_en), 32'h0);
        end
        step(0, 1, 0, 0);
        chk("resume_pc", pc_out, 32'hC);
        chk("resume_instr", instr_out, 32'hA000_0003);

        // Branch to 0x40 while presenting pc 4
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("pre_branch_pc", pc_out, 32'h4);
        step(0, 1, 1, 32'h40);
        chk("bubble_valid", 32'(valid_out), 32'h0);
        chk("bubble_instr", instr_out, 32'h0);
        step(0, 1, 0, 0);
        chk("target_pc", pc_out, 32'h40);
        chk("target_instr", instr_out, 32'hA000_0010);

        // Branch without PCWrite is ignored; then taken exactly once
        step(0, 0, 1, 32'h80);
        step(0, 0, 1, 32'h80);
        chk("ignored_br_pc", pc_out, 32'h40);
        step(0, 1, 1, 32'h80);
        step(0, 1, 0, 0);
        chk("br2_pc", pc_out, 32'h80);
        step(0, 1, 0, 0);
        chk("br2_next_pc", pc_out, 32'h84);

        // Reset while stalled at pc 0x10
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
        chk("pre_stall_pc", pc_out, 32'h10);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("mid_stall_rst_pc", pc_out, 32'h0);
        chk("mid_stall_rst_valid", 32'(valid_out), 32'h0);
        step(0, 1, 0, 0);
        chk("restart_instr", instr_out, 32'hA000_0000);

        // PC wrap; low target bits are ignored
        step(0, 1, 1, 32'hFFFF_FFFF);
        chk("wrap_addr_top", 32'(imem_addr), 32'h3FF);
        step(0, 1, 0, 0);
        chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
        chk("wrap_instr", instr_out, 32'hA000_03FF);
        chk("wrap_addr", 32'(imem_addr), 32'h0);
        step(0, 1, 0, 0);
        chk("wrapped_pc", pc_out, 32'h0);

        // Random stall/branch/reset traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0,
                 $urandom());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
